fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory, which may be multi-cycle (cache-backed).
- Delivers instruction and PC+2 to IF/ID, outputting NOP (16'h0FFF) whenever no valid instruction is available.
- Applies hazard-unit stall and branch/jump redirect; stops fetching after a HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0FFF, instruction word presented when fetch_valid=0.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard-unit hold; IF/ID is not consuming this cycle.
redirect  in  1  taken branch/jump resolved downstream; flush and refetch.
redirect_pc  in  16  redirect target.
imem_data  in  16  instruction word, valid when imem_done=1.
imem_done  in  1  memory completes the current request this cycle.
imem_stall  in  1  memory busy; request remains outstanding.
imem_rd  out  1  read request; held high with imem_addr stable until imem_done.
imem_addr  out  16  request address.
Instruction_out  out  16  instruction to IF/ID (NOP_INSTR when not valid).
PC_plus_two_out  out  16  delivered instruction address + 2, mod 2^16.
fetch_valid  out  1  Instruction_out is a real fetched instruction.
halt_fetched  out  1  HALT delivered; fetch stopped.
err  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - PC=RESET_PC, state FETCH, hold buffer empty.
  - imem_rd=0 during the reset cycle.
  - fetch_valid=0, Instruction_out=NOP_INSTR, PC_plus_two_out=0.
  - halt_fetched=0, err=0.
- States:
  - FETCH: imem_rd=1, imem_addr=PC, req_addr<=PC.
    - imem_done & !stall: deliver imem_data combinationally (fetch_valid=1, PC_plus_two_out=PC+2); PC<=PC+2; stay in FETCH.
    - imem_done & stall: capture data and address into the hold buffer; PC<=PC+2; go to HOLD.
    - !imem_done: go to WAIT.
  - WAIT: imem_rd=1, imem_addr=req_addr; fetch_valid=0.
    - On imem_done, deliver or hold exactly as in FETCH, then return to FETCH.
  - HOLD: imem_rd=0; present held instruction with fetch_valid=1.
    - stall=0 this cycle: entry is consumed; go to FETCH.
  - DROP: a request was outstanding when redirect arrived.
    - imem_rd=1 at req_addr until imem_done; data is discarded; fetch_valid=0.
    - Then go to FETCH at the new PC.
  - HALT: imem_rd=0, fetch_valid=0, halt_fetched=1.
- HALT detection: delivered instruction with [15:11]==5'b00000 enters HALT after delivery; PC is not advanced past it.
- Redirect has highest priority after reset and wins over stall, done and HALT:
  - PC<=redirect_pc; hold buffer cleared; halt_fetched cleared; fetch_valid=0 that cycle.
  - Request outstanding and not done this cycle: go to DROP.
  - Otherwise: go to FETCH.
  - A HALT fetched under a wrong-path branch is thereby cancelled.
- Redirect with redirect_pc[0]=1: err<=1 (sticky until reset); go to HALT (or DROP then HALT if a request is outstanding).
- PC arithmetic is 16-bit wrap: 16'hFFFE+2 = 16'h0000.
- imem_done and imem_stall never both high; if they are, imem_done wins.

Decomposition:
- Package fetch_pkg holds: NOP_INSTR, HALT_OPCODE (5'b00000), state enum {FETCH, WAIT, HOLD, DROP, HALT}.
- One sub-module: fetch_hold_buf, a one-entry instruction+PC+2 register with load/clear/valid.

Test Plan:
- Reset then single-cycle memory (done every cycle), no stall -> instructions at 0x0000, 0x0002, 0x0004 delivered on consecutive cycles; PC_plus_two_out = 0x0002, 0x0004, 0x0006.
- imem_stall for 3 cycles at PC 0x0010 -> imem_addr held at 0x0010, fetch_valid=0 for 3 cycles, then instruction delivered with PC_plus_two_out=0x0012.
- stall=1 in the same cycle as done at 0x0020 -> held word presented for 2 stall cycles with imem_rd=0; after stall drops, next request is 0x0022.
- redirect to 0x0100 while in WAIT at 0x0040 -> DROP holds addr 0x0040 until done, data discarded (fetch_valid=0), next imem_addr=0x0100.
- Fetch 16'h0000 (HALT) at 0x0030 -> halt_fetched=1, imem_rd=0 thereafter; redirect to 0x0050 -> halt_fetched=0, fetch resumes at 0x0050.
- redirect_pc=0x0101 -> err=1, HALT entered; err stays 1 across later redirects until rst.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and HALT decode for the fetch stage
package fetch_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0FFF;
  localparam logic [4:0] HALT_OPCODE = 5'b00000;
  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DROP, HALT} state_e;
  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus
interface fetch_unit_if;
  logic imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic imem_done;
  logic imem_stall;
  modport master (output imem_rd, imem_addr, input imem_data, imem_done, imem_stall);
  modport slave (input imem_rd, imem_addr, output imem_data, imem_done, imem_stall);
endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction + PC+2 buffer for words fetched while IF/ID stalls
module fetch_hold_buf (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic [15:0] instr_d,
  input  logic [15:0] ppt_d,
  output logic valid,
  output logic [15:0] instr,
  output logic [15:0] ppt
);
  always_ff @(posedge clk)
    if (rst || clear) valid <= 1'b0;
    else if (load) valid <= 1'b1;
  always_ff @(posedge clk)
    if (load) begin
      instr <= instr_d;
      ppt <= ppt_d;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-memory requester feeding the IF/ID register
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic redirect,
  input  logic [15:0] redirect_pc,
  fetch_unit_if.master mem,
  output logic [15:0] Instruction_out,
  output logic [15:0] PC_plus_two_out,
  output logic fetch_valid,
  output logic halt_fetched,
  output logic err
);
  import fetch_pkg::*;
  state_e state, state_n;
  logic [15:0] pc, pc_n, req_addr, cur_addr, hb_instr, hb_ppt;
  logic fetching, outstanding, done, accept, in_hold, deliver, hb_load, hb_clear, hb_valid;
  // imem_stall adds nothing beyond !imem_done; done wins if both are raised
  assign done = mem.imem_done & ~(mem.imem_stall & ~mem.imem_done);
  fetch_hold_buf u_hold (
    .clk(clk),
    .rst(rst),
    .load(hb_load),
    .clear(hb_clear),
    .instr_d(mem.imem_data),
    .ppt_d(cur_addr + 16'd2),
    .valid(hb_valid),
    .instr(hb_instr),
    .ppt(hb_ppt)
  );
  always_comb begin
    fetching = state == FETCH || state == WAIT;
    outstanding = fetching || state == DROP;
    cur_addr = state == FETCH ? pc : req_addr;
    accept = fetching && done;
    in_hold = state == HOLD && hb_valid;
    deliver = !redirect && ((accept && !stall) || in_hold);
    hb_load = !redirect && accept && stall;
    hb_clear = redirect || (state == HOLD && !stall);
    pc_n = redirect ? redirect_pc :
           accept ? (is_halt(mem.imem_data) ? cur_addr : cur_addr + 16'd2) : pc;
    state_n = redirect ? (outstanding && !done ? DROP : redirect_pc[0] ? HALT : FETCH) :
              fetching ? (!done ? WAIT : stall ? HOLD : is_halt(mem.imem_data) ? HALT : FETCH) :
              state == HOLD ? (stall ? HOLD : is_halt(hb_instr) ? HALT : FETCH) :
              state == DROP ? (!done ? DROP : pc[0] ? HALT : FETCH) : state;
    mem.imem_rd = !rst && outstanding;
    mem.imem_addr = cur_addr;
    fetch_valid = !rst && deliver;
    Instruction_out = !fetch_valid ? NOP_INSTR : in_hold ? hb_instr : mem.imem_data;
    PC_plus_two_out = !fetch_valid ? 16'h0000 : in_hold ? hb_ppt : cur_addr + 16'd2;
    halt_fetched = !rst && state == HALT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= cur_addr;
      if (redirect && redirect_pc[0]) err <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, memory waits, stalls, redirects and HALT
module tb_fetch_unit;
  localparam logic [15:0] HALT_ADDR = 16'h0030;
  logic clk = 1'b0;
  logic rst, stall, redirect, done, mstall;
  logic [15:0] redirect_pc;
  logic [15:0] instr, ppt;
  logic fetch_valid, halt_fetched, err;
  int checks = 0;
  int errors = 0;
  fetch_unit_if bus();
  assign bus.imem_done = done;
  assign bus.imem_stall = mstall;
  assign bus.imem_data = bus.imem_addr == HALT_ADDR ? 16'h0000 : {5'b10101, bus.imem_addr[10:0]};
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem(bus),
    .Instruction_out(instr),
    .PC_plus_two_out(ppt),
    .fetch_valid(fetch_valid),
    .halt_fetched(halt_fetched),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic [15:0] rp, input logic d, input logic ms, input logic st);
    redirect = r;
    redirect_pc = rp;
    done = d;
    mstall = ms;
    stall = st;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 0);
    go();
    check("rst_rd", 16'(bus.imem_rd), 16'd0);
    check("rst_valid", 16'(fetch_valid), 16'd0);
    check("rst_instr", instr, 16'h0FFF);
    check("rst_ppt", ppt, 16'h0000);
    check("rst_halt", 16'(halt_fetched), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    rst = 1'b0;
    drive(0, 16'h0, 1, 0, 0);
    check("f0_addr", bus.imem_addr, 16'h0000);
    check("f0_valid", 16'(fetch_valid), 16'd1);
    check("f0_instr", instr, 16'hA800);
    check("f0_ppt", ppt, 16'h0002);
    go();
    check("f2_instr", instr, 16'hA802);
    check("f2_ppt", ppt, 16'h0004);
    go();
    check("f4_addr", bus.imem_addr, 16'h0004);
    check("f4_ppt", ppt, 16'h0006);
    go();
    drive(1, 16'h0010, 1, 0, 0);
    check("redir_valid", 16'(fetch_valid), 16'd0);
    go();
    drive(0, 16'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", bus.imem_addr, 16'h0010);
      check("wait_rd", 16'(bus.imem_rd), 16'd1);
      check("wait_valid", 16'(fetch_valid), 16'd0);
      go();
    end
    drive(0, 16'h0, 1, 0, 0);
    check("wait_done_valid", 16'(fetch_valid), 16'd1);
    check("wait_done_instr", instr, 16'hA810);
    check("wait_done_ppt", ppt, 16'h0012);
    go();
    drive(1, 16'h0020, 1, 0, 0);
    check("after_wait_addr", bus.imem_addr, 16'h0012);
    go();
    drive(0, 16'h0, 1, 0, 1);
    check("capture_valid", 16'(fetch_valid), 16'd0);
    go();
    for (int i = 0; i < 2; i++) begin
      check("hold_rd", 16'(bus.imem_rd), 16'd0);
      check("hold_valid", 16'(fetch_valid), 16'd1);
      check("hold_instr", instr, 16'hA820);
      check("hold_ppt", ppt, 16'h0022);
      go();
    end
    drive(0, 16'h0, 1, 0, 0);
    check("consume_valid", 16'(fetch_valid), 16'd1);
    check("consume_instr", instr, 16'hA820);
    go();
    drive(1, 16'h0040, 1, 0, 0);
    check("post_hold_addr", bus.imem_addr, 16'h0022);
    check("post_hold_rd", 16'(bus.imem_rd), 16'd1);
    go();
    drive(0, 16'h0, 0, 1, 0);
    check("f40_addr", bus.imem_addr, 16'h0040);
    go();
    drive(1, 16'h0100, 0, 1, 0);
    check("wait_redir_valid", 16'(fetch_valid), 16'd0);
    go();
    drive(0, 16'h0, 0, 1, 0);
    check("drop_addr", bus.imem_addr, 16'h0040);
    check("drop_rd", 16'(bus.imem_rd), 16'd1);
    check("drop_valid", 16'(fetch_valid), 16'd0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("drop_done_addr", bus.imem_addr, 16'h0040);
    check("drop_done_valid", 16'(fetch_valid), 16'd0);
    go();
    check("after_drop_addr", bus.imem_addr, 16'h0100);
    drive(1, 16'h0030, 1, 0, 0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("halt_valid", 16'(fetch_valid), 16'd1);
    check("halt_instr", instr, 16'h0000);
    check("halt_ppt", ppt, 16'h0032);
    go();
    for (int i = 0; i < 2; i++) begin
      check("halted", 16'(halt_fetched), 16'd1);
      check("halted_rd", 16'(bus.imem_rd), 16'd0);
      check("halted_valid", 16'(fetch_valid), 16'd0);
      go();
    end
    drive(1, 16'h0050, 1, 0, 0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("resume_halt", 16'(halt_fetched), 16'd0);
    check("resume_addr", bus.imem_addr, 16'h0050);
    check("resume_rd", 16'(bus.imem_rd), 16'd1);
    drive(1, 16'hFFFE, 1, 0, 0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("wrap_instr", instr, 16'hAFFE);
    check("wrap_ppt", ppt, 16'h0000);
    go();
    check("wrap_addr", bus.imem_addr, 16'h0000);
    drive(1, 16'h0101, 1, 0, 0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("mis_err", 16'(err), 16'd1);
    check("mis_halt", 16'(halt_fetched), 16'd1);
    check("mis_rd", 16'(bus.imem_rd), 16'd0);
    drive(1, 16'h0060, 1, 0, 0);
    go();
    drive(0, 16'h0, 0, 1, 0);
    check("sticky_err", 16'(err), 16'd1);
    check("sticky_addr", bus.imem_addr, 16'h0060);
    drive(1, 16'h0103, 0, 1, 0);
    go();
    drive(0, 16'h0, 1, 0, 0);
    check("mis_drop_addr", bus.imem_addr, 16'h0060);
    check("mis_drop_valid", 16'(fetch_valid), 16'd0);
    go();
    check("mis_drop_halt", 16'(halt_fetched), 16'd1);
    check("mis_drop_rd", 16'(bus.imem_rd), 16'd0);
    rst = 1'b1;
    go();
    rst = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    check("rst2_err", 16'(err), 16'd0);
    check("rst2_addr", bus.imem_addr, 16'h0000);
    check("rst2_rd", 16'(bus.imem_rd), 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
